// File: rtl/btm_pkg.sv
// Shared widths and the reference truncated-multiply function for the
// bio-inspired truncated multiplier family.
package btm_pkg;

    localparam int BWOP_DEF    = 10;
    localparam int NAB_MAX_DEF = 4;

    function automatic int btm_nabw(input int nab_max);
        return (nab_max < 1) ? 1 : $clog2(nab_max + 1);
    endfunction

    localparam int NABW = btm_nabw(NAB_MAX_DEF);
    localparam int BWP  = 2 * BWOP_DEF;

    // Drop n LSBs from each operand, multiply exactly, then restore the
    // magnitude with a 2n left shift.
    function automatic logic [63:0] btm_trunc_mul(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input int unsigned n);
        logic [63:0] at;
        logic [63:0] bt;
        at = {32'd0, a >> n};
        bt = {32'd0, b >> n};
        return (at * bt) << (2 * n);
    endfunction

endpackage

// File: rtl/btm_pipe_slice.sv
// One pipeline slice: a valid bit plus a data word, both advancing when adv_in is high.
module btm_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_in,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= 1'b0;
        else if (adv_in)
            valid <= valid_in;
    end

    // Data carries no reset; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (adv_in)
            data <= data_in;
    end

endmodule

// File: rtl/btm_trunc_pipe.sv
// Pipelined truncated multiplier with per-transaction truncation depth and
// valid/ready handshakes on both sides.
module btm_trunc_pipe
    import btm_pkg::*;
#(
    parameter int BWOP    = BWOP_DEF,
    parameter int NAB_MAX = NAB_MAX_DEF,
    parameter int STAGES  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BWOP-1:0]              a,
    input  logic [BWOP-1:0]              b,
    input  logic [btm_nabw(NAB_MAX)-1:0] nab,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BWOP-1:0]              c,
    output logic [2*BWOP-1:0]            c_full,
    output logic                         busy
);

    localparam int NW = btm_nabw(NAB_MAX);
    localparam int PW = 2 * BWOP;
    localparam int DW = PW + NW;

    logic [STAGES:0]   adv;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] vld;
    logic [DW-1:0]     d_in [STAGES];
    logic [DW-1:0]     d_q  [STAGES];

    logic [NW-1:0]   n_in;
    logic [BWOP-1:0] at_in;
    logic [BWOP-1:0] bt_in;
    logic [PW-1:0]   p_out;
    logic [NW-1:0]   n_out;

    always_comb begin
        n_in  = (nab > NW'(NAB_MAX)) ? NW'(NAB_MAX) : nab;
        at_in = a >> n_in;
        bt_in = b >> n_in;
    end

    assign adv[STAGES] = out_ready;

    // Slices beyond the multiply carry {product, n}; the final 2n shift is
    // applied at the output so n never has to be re-derived.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign v_in[0] = in_valid;
                if (STAGES == 1) begin : g_mul
                    assign d_in[0] = {PW'(at_in) * PW'(bt_in), n_in};
                end else begin : g_opnd
                    assign d_in[0] = {at_in, bt_in, n_in};
                end
            end else if (k == 1) begin : g_mul
                logic [BWOP-1:0] at_s;
                logic [BWOP-1:0] bt_s;
                logic [NW-1:0]   n_s;
                assign {at_s, bt_s, n_s} = d_q[0];
                assign v_in[1] = vld[0];
                assign d_in[1] = {PW'(at_s) * PW'(bt_s), n_s};
            end else begin : g_pass
                assign v_in[k] = vld[k-1];
                assign d_in[k] = d_q[k-1];
            end

            assign adv[k] = !vld[k] || adv[k+1];

            btm_pipe_slice #(.W(DW)) u_slice (
                .clk      (clk),
                .rst      (rst),
                .adv_in   (adv[k]),
                .valid_in (v_in[k]),
                .data_in  (d_in[k]),
                .valid    (vld[k]),
                .data     (d_q[k])
            );
        end
    endgenerate

    always_comb begin
        p_out  = d_q[STAGES-1][DW-1:NW];
        n_out  = d_q[STAGES-1][NW-1:0];
        c_full = vld[STAGES-1] ? (p_out << {n_out, 1'b0}) : '0;
    end

    assign c         = c_full[BWOP-1:0];
    assign out_valid = vld[STAGES-1];
    assign in_ready  = adv[0];
    assign busy      = |vld;

endmodule

// File: tb/tb_btm_trunc_pipe.sv
// Directed bench for btm_trunc_pipe: latency, clamping, stalls, reset, random stream.
module tb_btm_trunc_pipe;
    import btm_pkg::*;

    localparam int BWOP    = 10;
    localparam int NAB_MAX = 4;
    localparam int STAGES  = 2;
    localparam int NW      = 3;
    localparam int PW      = 2 * BWOP;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BWOP-1:0] a = '0;
    logic [BWOP-1:0] b = '0;
    logic [NW-1:0]   nab = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [BWOP-1:0] c;
    logic [PW-1:0]   c_full;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [BWOP-1:0] ta [8] = '{10'd25, 10'd1023, 10'd100, 10'd512, 10'd1023, 10'd3, 10'd800, 10'd0};
    logic [BWOP-1:0] tb [8] = '{10'd30, 10'd1023, 10'd7, 10'd512, 10'd1023, 10'd5, 10'd900, 10'd1023};
    logic [NW-1:0]   tn [8] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd7, 3'd0, 3'd4, 3'd1};
    logic [PW-1:0]   te [8] = '{20'd750, 20'd1040400, 20'd600, 20'd262144,
                                20'd1016064, 20'd15, 20'd716800, 20'd0};
    bit              pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    btm_trunc_pipe #(.BWOP(BWOP), .NAB_MAX(NAB_MAX), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .nab       (nab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_full    (c_full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] model(input logic [BWOP-1:0] ma, input logic [BWOP-1:0] mb,
                                             input logic [NW-1:0] mn);
        int unsigned n;
        logic [63:0] r;
        n = (int'(mn) > NAB_MAX) ? NAB_MAX : int'(mn);
        r = btm_trunc_mul(32'(ma), 32'(mb), n);
        return r[PW-1:0];
    endfunction

    // One isolated transaction on an empty, unstalled pipe.
    task automatic send_one(input string tag, input logic [BWOP-1:0] va, input logic [BWOP-1:0] vb,
                            input logic [NW-1:0] vn, input logic [BWOP-1:0] exp_c,
                            input logic [PW-1:0] exp_full);
        a = va; b = vb; nab = vn; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        nab = 3'd0;
        for (int i = 0; i < STAGES - 1; i++) begin
            check_val({tag, "_early"}, 64'(out_valid), 64'd0);
            tick();
        end
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_c"}, 64'(c), 64'(exp_c));
        check_val({tag, "_cfull"}, 64'(c_full), 64'(exp_full));
        tick();
        check_val({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_stream(input string tag, input int total, input bit rnd);
        int sent = 0;
        int got = 0;
        int occ = 0;
        int cyc = 0;
        logic [PW-1:0] q [$];
        logic [PW-1:0] cur_exp;
        logic [PW-1:0] e;
        logic [PW-1:0] held_val = '0;
        logic held = 1'b0;
        while (got < total && cyc < 20 * total + 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
            if (sent < total && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                if (rnd) begin
                    a = BWOP'($urandom_range(0, 1023));
                    b = BWOP'($urandom_range(0, 1023));
                    nab = NW'($urandom_range(0, NAB_MAX + 2));
                    cur_exp = model(a, b, nab);
                end else begin
                    a = ta[sent]; b = tb[sent]; nab = tn[sent];
                    cur_exp = te[sent];
                end
            end else begin
                in_valid = 1'b0;
                a = BWOP'($urandom_range(0, 1023));
                cur_exp = '0;
            end
            @(negedge clk);
            if (held) begin
                check_val({tag, "_hold_cfull"}, 64'(c_full), 64'(held_val));
                check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            end
            check_val({tag, "_in_ready"}, 64'(in_ready), 64'((occ < STAGES) || out_ready));
            check_val({tag, "_busy"}, 64'(busy), 64'(occ != 0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val({tag, "_spurious"}, 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check_val({tag, "_cfull"}, 64'(c_full), 64'(e));
                    check_val({tag, "_c"}, 64'(c), 64'(e[BWOP-1:0]));
                end
                got++;
                occ--;
            end
            held = out_valid && !out_ready;
            held_val = c_full;
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                sent++;
                occ++;
            end
            tick();
            cyc++;
        end
        if (got < total)
            check_val({tag, "_timeout"}, 64'(got), 64'(total));
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int nres;
        logic [PW-1:0] seen;

        tick();
        tick();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_c", 64'(c), 64'd0);
        check_val("rst_cfull", 64'(c_full), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        send_one("d0", 10'd25,   10'd30,   3'd0, 10'd750, 20'd750);
        send_one("d1", 10'd1023, 10'd1023, 3'd2, 10'd16,  20'd1040400);
        send_one("d2", 10'd1023, 10'd1023, 3'd5, 10'd256, 20'd1016064);
        send_one("d3", 10'd1023, 10'd1023, 3'd7, 10'd256, 20'd1016064);
        send_one("d4", 10'd1023, 10'd1023, 3'd4, 10'd256, 20'd1016064);
        send_one("d5", 10'd1023, 10'd1023, 3'd0, 10'd1,   20'd1046529);
        send_one("d6", 10'd1000, 10'd3,    3'd1, 10'd976, 20'd2000);
        send_one("d7", 10'd1023, 10'd1023, 3'd3, 10'd64,  20'd1032256);

        run_stream("stall", 8, 1'b0);

        // Two in flight, then an asynchronous reset between edges.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 10'd1023; b = 10'd1023; nab = 3'd0;
        tick();
        a = 10'd7; b = 10'd9;
        tick();
        in_valid = 1'b0;
        check_val("pre_rst_busy", 64'(busy), 64'd1);
        check_val("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_c", 64'(c), 64'd0);
        check_val("mid_rst_cfull", 64'(c_full), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; a = 10'd25; b = 10'd30; nab = 3'd0;
        tick();
        in_valid = 1'b0;
        nres = 0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                nres++;
                seen = c_full;
            end
            tick();
        end
        check_val("post_rst_count", 64'(nres), 64'd1);
        check_val("post_rst_cfull", 64'(seen), 64'd750);

        run_stream("rand", 300, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
